spi_master_ctrl: RTL and testbench

Synthesizable SPI master controller: the initiator end of the SPI link that the slave-side driver/monitor BFMs respond to. It accepts one word per valid/ready handshake from a local host, drives `sclk`, `cs` and `mosi0`, and samples `miso0`. It presents the received word on a one-cycle strobe. It sits in `hdl_top` as the RTL master (DUT stand-in) on the same `spi_if` signals, supporting all four CPOL/CPHA modes, MSB first.

---
 rtl/spi_master_pkg.sv | 27 ++
 rtl/spi_master_sclk_gen.sv | 77 +++++++
 rtl/spi_master_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg
// Shared types for the SPI master controller.
//   spi_master_state_e : controller FSM states
//   spi_mode_s         : clock polarity/phase pair for one transfer
//   clog2_min1()       : counter/index width helper, never returns 0
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } spi_master_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_s;

  // Width needed to hold values 0..n-1; a 1-bit field is kept even for n<=2
  // so that a single-slave select port or a one-cycle timer still exists.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// spi_sclk_gen
// Serial clock generator for the SPI master.
//   pclk, areset : system clock, async active-low reset
//   load, cpol   : on load, sclk takes the idle level of the new transfer
//   en           : runs the half-period timer (high in LEAD and SHIFT)
//   sclk         : registered serial clock
//   lead_edge    : this pclk edge registers an odd (leading) sclk edge
//   trail_edge   : this pclk edge registers an even (trailing) sclk edge
//   last_edge    : this pclk edge registers edge 2*DATA_WIDTH
module spi_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int SCLK_HALF_PERIOD = 2
) (
  input  logic pclk,
  input  logic areset,
  input  logic load,
  input  logic cpol,
  input  logic en,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge
);

  localparam int HCW = clog2_min1(SCLK_HALF_PERIOD);
  localparam int ECW = clog2_min1(2 * DATA_WIDTH + 1);
  localparam logic [HCW-1:0] HALF_TC  = HCW'(SCLK_HALF_PERIOD - 1);
  localparam logic [ECW-1:0] LAST_IDX = ECW'(2 * DATA_WIDTH - 1);

  logic [HCW-1:0] half_cnt_q, half_cnt_d;
  logic [ECW-1:0] edge_idx_q, edge_idx_d;
  logic           sclk_q, sclk_d;
  logic           edge_now;

  // The LEAD half-period is timed here too, so edge 1 falls exactly one
  // half-period after chip select drops.
  assign edge_now   = en && (half_cnt_q == '0);
  // edge_idx_q counts edges already made; the upcoming edge is edge_idx_q+1.
  assign lead_edge  = edge_now && !edge_idx_q[0];
  assign trail_edge = edge_now &&  edge_idx_q[0];
  assign last_edge  = edge_now && (edge_idx_q == LAST_IDX);
  assign sclk       = sclk_q;

  always_comb begin
    half_cnt_d = half_cnt_q;
    edge_idx_d = edge_idx_q;
    sclk_d     = sclk_q;
    if (!en) begin
      half_cnt_d = HALF_TC;
      edge_idx_d = '0;
    end else if (edge_now) begin
      half_cnt_d = HALF_TC;
      edge_idx_d = edge_idx_q + 1'b1;
      sclk_d     = ~sclk_q;
    end else begin
      half_cnt_d = half_cnt_q - 1'b1;
    end
    if (load) begin
      sclk_d = cpol;
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      half_cnt_q <= HALF_TC;
      edge_idx_q <= '0;
      sclk_q     <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      edge_idx_q <= edge_idx_d;
      sclk_q     <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI master: one word per tx_valid/tx_ready handshake, MSB first, all four
// CPOL/CPHA modes, received word presented on a one-cycle rx_valid strobe.
//   pclk, areset           : system clock, async active-low reset
//   tx_valid/tx_ready      : host request / accept (ready only in IDLE)
//   tx_data, tx_cpol,
//   tx_cpha, tx_slave_sel  : word, mode and target, latched at accept
//   rx_valid, rx_data      : completion strobe and held received word
//   busy                   : high outside IDLE
//   sclk, cs, mosi0, miso0 : SPI bus (cs active low)
//
// state | meaning
// IDLE  | ready for a request, sclk parked at last CPOL
// LEAD  | cs asserted, first half-period before edge 1
// SHIFT | sclk toggling, edges 2..2W
// TRAIL | cs held low one half-period after the last edge
// GAP   | cs released one half-period before the next request
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int  DATA_WIDTH       = 8,
  parameter int  NO_OF_SLAVES     = 1,
  parameter int  SCLK_HALF_PERIOD = 2,
  localparam int SEL_W            = clog2_min1(NO_OF_SLAVES)
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_cpol,
  input  logic                    tx_cpha,
  input  logic [SEL_W-1:0]        tx_slave_sel,
  output logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    busy,
  output logic                    sclk,
  output logic [NO_OF_SLAVES-1:0] cs,
  output logic                    mosi0,
  input  logic                    miso0
);

  localparam int HCW = clog2_min1(SCLK_HALF_PERIOD);
  localparam logic [HCW-1:0] HALF_TC = HCW'(SCLK_HALF_PERIOD - 1);

  spi_master_state_e state_q, state_d;
  logic                    cpha_q, cpha_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [NO_OF_SLAVES-1:0] cs_q, cs_d;
  logic                    mosi_q, mosi_d;
  logic [HCW-1:0]          timer_q, timer_d;

  spi_mode_s tx_mode;
  logic      accept;
  logic      gen_en;
  logic      lead_edge, trail_edge, last_edge;

  // Out-of-range selects match no bit, leaving every chip select high.
  function automatic logic [NO_OF_SLAVES-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [NO_OF_SLAVES-1:0] v;
    v = '1;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (SEL_W'(i) == sel) begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign tx_mode = '{cpol: tx_cpol, cpha: tx_cpha};
  assign accept  = tx_valid && (state_q == IDLE);
  assign gen_en  = (state_q == LEAD) || (state_q == SHIFT);

  spi_sclk_gen #(
    .DATA_WIDTH      (DATA_WIDTH),
    .SCLK_HALF_PERIOD(SCLK_HALF_PERIOD)
  ) u_sclk_gen (
    .pclk      (pclk),
    .areset    (areset),
    .load      (accept),
    .cpol      (tx_mode.cpol),
    .en        (gen_en),
    .sclk      (sclk),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .last_edge (last_edge)
  );

  always_comb begin
    state_d    = state_q;
    cpha_d     = cpha_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    timer_d    = timer_q;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d    = LEAD;
          cpha_d     = tx_mode.cpha;
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          cs_d       = cs_decode(tx_slave_sel);
          // CPHA=0 must present the MSB before the first edge.
          mosi_d     = tx_mode.cpha ? 1'b0 : tx_data[DATA_WIDTH-1];
        end
      end
      LEAD: begin
        if (lead_edge) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_edge) begin
          state_d = TRAIL;
          timer_d = HALF_TC;
        end
      end
      TRAIL: begin
        if (timer_q == '0) begin
          state_d    = GAP;
          timer_d    = HALF_TC;
          cs_d       = '1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Edge strobes only occur in LEAD/SHIFT. The sampling edge captures the
    // miso0 level present before this pclk edge, while mosi0 changes after it.
    if (lead_edge) begin
      if (!cpha_q) begin
        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso0};
      end else begin
        mosi_d     = tx_shift_q[DATA_WIDTH-1];
        tx_shift_d = tx_shift_q << 1;
      end
    end
    if (trail_edge) begin
      if (cpha_q) begin
        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], miso0};
      end else if (!last_edge) begin
        // tx_shift_q[W-1] is already on the wire, so the next bit is one below.
        mosi_d     = tx_shift_q[DATA_WIDTH-2];
        tx_shift_d = tx_shift_q << 1;
      end
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state_q    <= IDLE;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_q       <= '1;
      mosi_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      cpha_q     <= cpha_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      timer_q    <= timer_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign cs       = cs_q;
  assign mosi0    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl. Instance A: W=8, H=2, 4 slaves.
// Instance B: W=2, H=1, 3 slaves (a 2-bit select can then encode an
// out-of-range index). Outputs are sampled 1ns after the rising pclk edge.
module tb_spi_master_ctrl;

  logic pclk;
  logic areset;
  int   cyc = 0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // instance A
  logic       a_tx_valid, a_tx_ready, a_cpol, a_cpha;
  logic [7:0] a_tx_data, a_rx_data;
  logic [1:0] a_sel;
  logic       a_rx_valid, a_busy, a_sclk, a_mosi, a_miso;
  logic [3:0] a_cs;

  // instance B
  logic       b_tx_valid, b_tx_ready, b_cpol, b_cpha;
  logic [1:0] b_tx_data, b_rx_data, b_sel;
  logic       b_rx_valid, b_busy, b_sclk, b_mosi, b_miso;
  logic [2:0] b_cs;

  spi_master_ctrl #(.DATA_WIDTH(8), .NO_OF_SLAVES(4), .SCLK_HALF_PERIOD(2)) u_dut_a (
    .pclk(pclk), .areset(areset), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_data(a_tx_data), .tx_cpol(a_cpol), .tx_cpha(a_cpha), .tx_slave_sel(a_sel),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy), .sclk(a_sclk),
    .cs(a_cs), .mosi0(a_mosi), .miso0(a_miso)
  );

  spi_master_ctrl #(.DATA_WIDTH(2), .NO_OF_SLAVES(3), .SCLK_HALF_PERIOD(1)) u_dut_b (
    .pclk(pclk), .areset(areset), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_data(b_tx_data), .tx_cpol(b_cpol), .tx_cpha(b_cpha), .tx_slave_sel(b_sel),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy), .sclk(b_sclk),
    .cs(b_cs), .mosi0(b_mosi), .miso0(b_miso)
  );

  // Mode-0 slave for A: MSB from cs fall, next bit after each rising sclk.
  logic       a_loop   = 1'b1;
  logic [7:0] slv_word = 8'h00;
  int         rises    = 0;
  logic       sclk_prev  = 1'b0;
  logic       cs_hi_prev = 1'b1;
  logic [7:0] mosi_cap   = 8'h00;

  always @(posedge pclk) begin
    #1;
    if (cs_hi_prev && !(&a_cs)) begin
      rises    = 0;
      mosi_cap = 8'h00;
    end else if (!(&a_cs) && a_sclk && !sclk_prev) begin
      rises    = rises + 1;
      mosi_cap = {mosi_cap[6:0], a_mosi};
    end
    sclk_prev  = a_sclk;
    cs_hi_prev = &a_cs;
  end

  assign a_miso = a_loop ? a_mosi : ((rises < 8) ? slv_word[3'(7 - rises)] : 1'b0);
  assign b_miso = b_mosi;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One transfer on A, starting in an IDLE cycle; returns in IDLE at N+37.
  task automatic run_a(input logic [7:0] data, input logic cpol, input logic cpha,
                       input logic [1:0] sel, input logic [3:0] exp_cs,
                       input logic [7:0] exp_rx, input string tag);
    int  n;
    bit  seen;
    a_tx_data  = data;
    a_cpol     = cpol;
    a_cpha     = cpha;
    a_sel      = sel;
    a_tx_valid = 1'b1;
    n = cyc;
    tick();
    a_tx_valid = 1'b0;
    chk({tag, ":cs_lead"}, 32'(a_cs), 32'(exp_cs));
    chk({tag, ":sclk_lead"}, 32'(a_sclk), 32'(cpol));
    chk({tag, ":mosi_lead"}, 32'(a_mosi), cpha ? 32'd0 : 32'(data[7]));
    tick();
    tick();
    chk({tag, ":sclk_edge1"}, 32'(a_sclk), 32'(!cpol));
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (a_rx_valid) seen = 1'b1;
    end
    chk({tag, ":rx_seen"}, 32'(seen), 32'd1);
    chk({tag, ":rx_cycle"}, 32'(cyc - n), 32'd35);
    chk({tag, ":rx_data"}, 32'(a_rx_data), 32'(exp_rx));
    chk({tag, ":cs_done"}, 32'(a_cs), 32'hF);
    tick();
    chk({tag, ":rx_pulse"}, 32'(a_rx_valid), 32'd0);
    chk({tag, ":ready_gap"}, 32'(a_tx_ready), 32'd0);
    tick();
    chk({tag, ":ready_idle"}, 32'(a_tx_ready), 32'd1);
    chk({tag, ":sclk_idle"}, 32'(a_sclk), 32'(cpol));
  endtask

  int n;
  bit seen;

  initial begin
    areset     = 1'b0;
    a_tx_valid = 1'b0; a_tx_data = 8'h00; a_cpol = 1'b0; a_cpha = 1'b0; a_sel = 2'd0;
    b_tx_valid = 1'b0; b_tx_data = 2'd0;  b_cpol = 1'b0; b_cpha = 1'b0; b_sel = 2'd0;
    tick();
    tick();
    chk("rst:ready", 32'(a_tx_ready), 32'd1);
    chk("rst:busy", 32'(a_busy), 32'd0);
    chk("rst:sclk", 32'(a_sclk), 32'd0);
    chk("rst:cs", 32'(a_cs), 32'hF);
    chk("rst:mosi", 32'(a_mosi), 32'd0);
    chk("rst:rx_valid", 32'(a_rx_valid), 32'd0);
    chk("rst:rx_data", 32'(a_rx_data), 32'd0);
    areset = 1'b1;
    tick();

    // all four modes, loopback of 8'h81
    a_loop = 1'b1;
    for (int m = 0; m < 4; m++) begin
      run_a(8'h81, 1'(m >> 1), 1'(m & 1), 2'd0, 4'b1110, 8'h81, $sformatf("mode%0d", m));
    end

    // mode 0, A5 out, slave returns 3C, slave 2 selected
    a_loop   = 1'b0;
    slv_word = 8'h3C;
    run_a(8'hA5, 1'b0, 1'b0, 2'd2, 4'b1011, 8'h3C, "m0_a5");
    chk("m0_a5:mosi_bits", 32'(mosi_cap), 32'hA5);
    a_loop = 1'b1;

    // back-to-back with tx_valid held
    a_cpol = 1'b0; a_cpha = 1'b0; a_sel = 2'd0;
    a_tx_data  = 8'h01;
    a_tx_valid = 1'b1;
    n = cyc;
    tick();
    a_tx_data = 8'hFE;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (a_rx_valid) seen = 1'b1;
    end
    chk("b2b:rx1_seen", 32'(seen), 32'd1);
    chk("b2b:rx1_cycle", 32'(cyc - n), 32'd35);
    chk("b2b:rx1_data", 32'(a_rx_data), 32'h01);
    chk("b2b:cs_gap0", 32'(a_cs), 32'hF);
    tick();
    chk("b2b:cs_gap1", 32'(a_cs), 32'hF);
    chk("b2b:ready_gap", 32'(a_tx_ready), 32'd0);
    tick();
    chk("b2b:ready_idle", 32'(a_tx_ready), 32'd1);
    tick();
    chk("b2b:cs_second", 32'(a_cs), 32'b1110);
    chk("b2b:rx_hold", 32'(a_rx_data), 32'h01);
    a_tx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (a_rx_valid) seen = 1'b1;
    end
    chk("b2b:rx2_seen", 32'(seen), 32'd1);
    chk("b2b:rx2_cycle", 32'(cyc - n), 32'd72);
    chk("b2b:rx2_data", 32'(a_rx_data), 32'hFE);
    tick();
    tick();

    // reset at edge 7 of a transfer
    a_tx_data  = 8'hC3;
    a_cpol     = 1'b0;
    a_cpha     = 1'b0;
    a_sel      = 2'd0;
    a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    repeat (14) tick();
    chk("arst:sclk_edge7", 32'(a_sclk), 32'd1);
    chk("arst:busy_before", 32'(a_busy), 32'd1);
    areset = 1'b0;
    #1;
    chk("arst:cs", 32'(a_cs), 32'hF);
    chk("arst:sclk", 32'(a_sclk), 32'd0);
    chk("arst:busy", 32'(a_busy), 32'd0);
    chk("arst:ready", 32'(a_tx_ready), 32'd1);
    chk("arst:rx_data", 32'(a_rx_data), 32'd0);
    tick();
    areset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_rx_valid) seen = 1'b1;
    end
    chk("arst:no_rx", 32'(seen), 32'd0);
    run_a(8'h5A, 1'b0, 1'b0, 2'd1, 4'b1101, 8'h5A, "post_rst");

    // instance B: H=1, W=2, in-range slave 1, mode 0
    b_tx_data  = 2'b10;
    b_sel      = 2'd1;
    b_cpol     = 1'b0;
    b_cpha     = 1'b0;
    b_tx_valid = 1'b1;
    n = cyc;
    tick();
    b_tx_valid = 1'b0;
    chk("b_m0:cs", 32'(b_cs), 32'b101);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (b_rx_valid) seen = 1'b1;
    end
    chk("b_m0:rx_seen", 32'(seen), 32'd1);
    chk("b_m0:rx_cycle", 32'(cyc - n), 32'd6);
    chk("b_m0:rx_data", 32'(b_rx_data), 32'b10);
    tick();
    chk("b_m0:ready", 32'(b_tx_ready), 32'd1);

    // instance B: out-of-range select 3, mode 3, request pulsed while busy
    b_tx_data  = 2'b01;
    b_sel      = 2'd3;
    b_cpol     = 1'b1;
    b_cpha     = 1'b1;
    b_tx_valid = 1'b1;
    n = cyc;
    tick();
    b_tx_valid = 1'b0;
    chk("b_oor:cs", 32'(b_cs), 32'b111);
    tick();
    b_tx_data  = 2'b11;
    b_tx_valid = 1'b1;
    tick();
    tick();
    b_tx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (b_rx_valid) seen = 1'b1;
    end
    chk("b_oor:rx_seen", 32'(seen), 32'd1);
    chk("b_oor:rx_cycle", 32'(cyc - n), 32'd6);
    chk("b_oor:rx_data", 32'(b_rx_data), 32'b01);
    tick();
    chk("b_oor:ready", 32'(b_tx_ready), 32'd1);
    tick();
    chk("b_oor:no_queue", 32'(b_busy), 32'd0);
    chk("b_oor:sclk_idle", 32'(b_sclk), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "simulation time limit");
  end

endmodule
